// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding imem req/ack fetcher feeding a
// small prefetch FIFO, with a registered IR/PC/if_valid output to decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] IR,
  output logic [31:0] PC,
  output logic        if_valid
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ir_q, ir_d, pc_q, pc_d;
  logic          valid_q, valid_d;
  logic [31:0]   fifo_pc_q [FIFO_DEPTH];
  logic [31:0]   fifo_ir_q [FIFO_DEPTH];
  logic          done, push, pop, can_issue;

  // Memory handshake: a request completes on any edge with req && ack; until
  // then req/addr stay frozen, and only one request is ever outstanding.
  always_comb begin
    done = req_q && imem_ack;
    push = done && (state_q == S_WAIT) && !redirect;
    pop  = !redirect && !stall && (count_q != '0);
    if (redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      count_d    = count_q + CW'(push) - CW'(pop);
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      fetch_pc_d = push ? fetch_pc_q + 32'd4 : fetch_pc_q;
    end
    // The bus is free when idle or when the outstanding request completes now.
    can_issue = ((state_q == S_FETCH) || done) && (count_d < CW'(FIFO_DEPTH));
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    if (can_issue) begin
      state_d = S_WAIT;
      req_d   = 1'b1;
      addr_d  = fetch_pc_d;
    end else if (done) begin
      state_d = S_FETCH;
      req_d   = 1'b0;
    end else if (redirect && (state_q == S_WAIT)) begin
      state_d = S_FLUSH;
    end
  end

  always_comb begin
    ir_d    = ir_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (redirect) begin
      ir_d    = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (count_q != '0) begin
        ir_d    = fifo_ir_q[rd_ptr_q];
        pc_d    = fifo_pc_q[rd_ptr_q];
        valid_d = 1'b1;
      end else begin
        ir_d    = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ir_q       <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q] <= fetch_pc_q;
      fifo_ir_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign IR        = ir_q;
  assign PC        = pc_q;
  assign if_valid  = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: wait-state memory model, in-order PC stream
// reference, directed scenarios, then a randomized stall/redirect/reset run.
module tb_instruction_fetch;

  localparam logic [31:0] KEY      = 32'hA5A5_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] IR;
  logic [31:0] PC;
  logic        if_valid;

  int tests = 0;
  int fails = 0;

  instruction_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .IR(IR), .PC(PC), .if_valid(if_valid)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Values seen at the most recent active edge (pre-update DUT outputs).
  logic        mon_on = 1'b0;
  logic        e_rst = 1'b0, e_stall = 1'b0, e_red = 1'b0;
  logic [31:0] e_rpc = 32'h0;
  logic        p_req = 1'b0, p_ack = 1'b0, p_valid = 1'b0;
  logic [31:0] p_addr = 32'h0, p_ir = 32'h0, p_pc = 32'h0;

  always @(posedge clk) begin
    e_rst   = rst;
    e_stall = stall;
    e_red   = redirect;
    e_rpc   = redirect_pc;
    p_req   = imem_req;
    p_ack   = imem_ack;
    p_addr  = imem_addr;
    p_ir    = IR;
    p_pc    = PC;
    p_valid = if_valid;
    mon_on  = 1'b1;
  end

  // memory model: each request is acked after mem_wait idle cycles
  int mem_wait  = 0;
  int wait_left = 0;
  always @(negedge clk) begin
    if (!e_rst || (p_req === 1'b1 && p_ack === 1'b1)) wait_left = mem_wait;
    if (imem_req === 1'b1 && wait_left == 0) begin
      imem_ack   = 1'b1;
      imem_rdata = imem_addr ^ KEY;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (imem_req === 1'b1) wait_left--;
    end
  end

  // scoreboard: valid instructions must form the in-order stream from the last
  // reset/redirect target, each carrying its own memory word
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  always @(negedge clk) begin
    if (mon_on) begin
      if (!e_rst) begin
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_addr",  imem_addr, RESET_PC);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_ir",    IR, 32'd0);
        check("rst_pc",    PC, 32'd0);
        exp_q.delete();
        exp_q.push_back(RESET_PC);
      end else begin
        check("addr_align", 32'(imem_addr[1:0]), 32'd0);
        if (p_req === 1'b1 && p_ack !== 1'b1) begin
          check("bus_hold_req",  32'(imem_req), 32'd1);
          check("bus_hold_addr", imem_addr, p_addr);
        end
        if (e_red) begin
          check("redir_valid", 32'(if_valid), 32'd0);
          check("redir_ir",    IR, 32'd0);
          check("redir_pc",    PC, p_pc);
          exp_q.delete();
          exp_q.push_back({e_rpc[31:2], 2'b00});
        end else if (e_stall) begin
          check("stall_ir",    IR, p_ir);
          check("stall_pc",    PC, p_pc);
          check("stall_valid", 32'(if_valid), 32'(p_valid));
        end else if (if_valid === 1'b1) begin
          exp_pc = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
          check("seq_pc", PC, exp_pc);
          check("seq_ir", IR, exp_pc ^ KEY);
          exp_q.push_back(exp_pc + 32'd4);
        end else begin
          check("bubble_ir", IR, 32'd0);
          check("bubble_pc", PC, p_pc);
        end
      end
    end
  end

  int          nvalid;
  logic [31:0] held_pc;
  logic        found;

  initial begin
    // reset / startup
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("start_req", 32'(imem_req), 32'd1);
    check("start_addr", imem_addr, 32'h0);
    check("start_valid", 32'(if_valid), 32'd0);
    step();
    check("start_addr1", imem_addr, 32'h4);
    check("start_valid1", 32'(if_valid), 32'd0);
    step();
    check("first_valid", 32'(if_valid), 32'd1);
    check("first_ir", IR, KEY);
    check("first_pc", PC, 32'h0);
    check("first_addr", imem_addr, 32'h8);
    for (int i = 0; i < 6; i++) begin
      step();
      check("thru_valid", 32'(if_valid), 32'd1);
    end

    // stall until full
    held_pc = PC;
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 1) check("full_req", 32'(imem_req), 32'd0);
    end
    check("full_addr", imem_addr, held_pc + 32'd8);
    stall = 1'b0;
    step();
    check("unstall_pc", PC, held_pc + 32'd4);
    check("unstall_req", 32'(imem_req), 32'd1);
    check("unstall_addr", imem_addr, held_pc + 32'd12);
    step();
    check("unstall_pc2", PC, held_pc + 32'd8);

    // wait states
    mem_wait = 2;
    repeat (6) step();
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (if_valid === 1'b1) nvalid++;
    end
    check("wait_valid_cnt", nvalid, 32'd4);

    // redirect while the request to 8 is waiting
    rst = 1'b0;
    step();
    rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = (imem_req === 1'b1) && (imem_addr === 32'h8);
    end
    check("found_req8", 32'(found), 32'd1);
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    check("flush_req", 32'(imem_req), 32'd1);
    check("flush_addr", imem_addr, 32'h8);
    step();
    check("post_flush_addr", imem_addr, 32'h100);
    check("post_flush_valid", 32'(if_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = (if_valid === 1'b1);
    end
    check("redir_arrive", 32'(found), 32'd1);
    check("redir_arrive_pc", PC, 32'h100);

    // redirect + stall + completion on one edge
    mem_wait = 0;
    repeat (6) step();
    check("pre_req", 32'(imem_req), 32'd1);
    check("pre_ack", 32'(imem_ack), 32'd1);
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    check("rs_valid", 32'(if_valid), 32'd0);
    check("rs_addr", imem_addr, 32'h100);
    check("rs_req", 32'(imem_req), 32'd1);
    repeat (2) step();
    check("rs_full_req", 32'(imem_req), 32'd0);
    stall = 1'b0;
    step();
    check("rs_out_valid", 32'(if_valid), 32'd1);
    check("rs_out_pc", PC, 32'h100);
    check("rs_out_ir", IR, 32'h100 ^ KEY);

    // address wrap
    repeat (3) step();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr1", imem_addr, 32'h0);
    step();
    check("wrap_pc0", PC, 32'hFFFF_FFFC);
    step();
    check("wrap_pc1", PC, 32'h0);

    // reset during WAIT
    mem_wait = 2;
    repeat (6) step();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = (imem_req === 1'b1) && (imem_ack === 1'b0);
    end
    check("found_wait", 32'(found), 32'd1);
    rst = 1'b0;
    step();
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_valid", 32'(if_valid), 32'd0);
    rst = 1'b1;
    step();
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", imem_addr, RESET_PC);

    // randomized run
    nvalid = 0;
    for (int i = 0; i < 600; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      mem_wait    = $urandom_range(0, 3);
      rst         = ($urandom_range(0, 149) != 0);
      step();
      if (if_valid === 1'b1) nvalid++;
    end
    stall = 1'b0;
    redirect = 1'b0;
    rst = 1'b1;
    repeat (10) step();
    check("rand_progress", 32'(nvalid > 50), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
